// File: rtl/s_resp_block_if.sv
// Master/slave request-response bus for s_resp_block: two requesting masters on one side,
// a single downstream slave port on the other.
interface s_resp_block_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // Master 0 side
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_cmd;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic          m0_resp;
  logic [DW-1:0] m0_rdata;
  // Master 1 side
  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_cmd;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic          m1_resp;
  logic [DW-1:0] m1_rdata;
  // Downstream slave side
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic          s_cmd;
  logic [DW-1:0] s_wdata;
  logic          s_ack;
  logic [DW-1:0] s_rdata;

  // Environment view: drives master requests and the downstream slave's answers.
  modport master (
    output m0_req, m0_addr, m0_cmd, m0_wdata,
    output m1_req, m1_addr, m1_cmd, m1_wdata,
    output s_ack, s_rdata,
    input  m0_ack, m0_resp, m0_rdata,
    input  m1_ack, m1_resp, m1_rdata,
    input  s_req, s_addr, s_cmd, s_wdata
  );

  // Arbiter view: the block that serves both masters.
  modport slave (
    input  m0_req, m0_addr, m0_cmd, m0_wdata,
    input  m1_req, m1_addr, m1_cmd, m1_wdata,
    input  s_ack, s_rdata,
    output m0_ack, m0_resp, m0_rdata,
    output m1_ack, m1_resp, m1_rdata,
    output s_req, s_addr, s_cmd, s_wdata
  );
endinterface

// File: rtl/s_resp_block.sv
// Two-master round-robin arbiter in front of a single slave. One transaction at a time:
// IDLE grants, BUSY waits for s_ack, RDATA returns one beat of read data.
module s_resp_block #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  s_resp_block_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StRdata = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   ptr_q, ptr_d;
  logic   cmd_q, cmd_d;

  logic          gnt_req;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_wdata;
  logic          fwd_cmd;

  // Fields of the currently granted master.
  always_comb begin
    gnt_req   = grant_q ? bus.m1_req   : bus.m0_req;
    fwd_addr  = grant_q ? bus.m1_addr  : bus.m0_addr;
    fwd_wdata = grant_q ? bus.m1_wdata : bus.m0_wdata;
    fwd_cmd   = grant_q ? bus.m1_cmd   : bus.m0_cmd;
  end

  // Next-state, arbitration and all outputs; rst forces every output low.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cmd_d        = cmd_q;
    bus.s_req    = 1'b0;
    bus.s_addr   = '0;
    bus.s_cmd    = 1'b0;
    bus.s_wdata  = '0;
    bus.m0_ack   = 1'b0;
    bus.m1_ack   = 1'b0;
    bus.m0_resp  = 1'b0;
    bus.m1_resp  = 1'b0;
    bus.m0_rdata = '0;
    bus.m1_rdata = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.m0_req || bus.m1_req) begin
          // Pointer only matters when both request at once.
          grant_d = (bus.m0_req && bus.m1_req) ? ptr_q : bus.m1_req;
          cmd_d   = grant_d ? bus.m1_cmd : bus.m0_cmd;
          state_d = StBusy;
        end
      end
      StBusy: begin
        bus.s_req   = gnt_req;
        bus.s_addr  = fwd_addr;
        bus.s_cmd   = fwd_cmd;
        bus.s_wdata = fwd_wdata;
        if (!gnt_req) begin
          // Master withdrew before acceptance: abandon, keep the pointer.
          state_d = StIdle;
        end else if (bus.s_ack) begin
          if (grant_q) bus.m1_ack = 1'b1;
          else         bus.m0_ack = 1'b1;
          if (cmd_q) begin
            state_d = StIdle;
            ptr_d   = ~grant_q;
          end else begin
            state_d = StRdata;
          end
        end
      end
      StRdata: begin
        if (grant_q) begin
          bus.m1_resp  = 1'b1;
          bus.m1_rdata = bus.s_rdata;
        end else begin
          bus.m0_resp  = 1'b1;
          bus.m0_rdata = bus.s_rdata;
        end
        ptr_d   = ~grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      bus.s_req    = 1'b0;
      bus.s_addr   = '0;
      bus.s_cmd    = 1'b0;
      bus.s_wdata  = '0;
      bus.m0_ack   = 1'b0;
      bus.m1_ack   = 1'b0;
      bus.m0_resp  = 1'b0;
      bus.m1_resp  = 1'b0;
      bus.m0_rdata = '0;
      bus.m1_rdata = '0;
    end
  end

  // State, grant, pointer and command registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      cmd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
    end
  end

endmodule
